// File: rtl/stage_sequencer_if.sv
// rtl/stage_sequencer_if.sv - control and status bundle for the stage sequencer
interface stage_sequencer_if #(
  parameter int NUM_STAGES  = 5,
  parameter int NUM_SOURCES = 4,
  parameter int CNT_WIDTH   = 8
);
  localparam int SEL_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic                              stall;
  logic                              advance;
  logic                              jump_valid;
  logic [SEL_W-1:0]                  jump_sel;
  logic [NUM_SOURCES*NUM_STAGES-1:0] jump_targets;
  logic [NUM_STAGES-1:0]             stage;
  logic [IDX_W-1:0]                  stage_idx;
  logic                              wrapped;
  logic [CNT_WIDTH-1:0]              stage_cycles;
  logic                              jump_err;
  logic                              jump_err_sticky;

  modport master (
    output stall, advance, jump_valid, jump_sel, jump_targets,
    input  stage, stage_idx, wrapped, stage_cycles, jump_err, jump_err_sticky
  );

  modport slave (
    input  stall, advance, jump_valid, jump_sel, jump_targets,
    output stage, stage_idx, wrapped, stage_cycles, jump_err, jump_err_sticky
  );
endinterface

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - registered one-hot stage sequencer with hold, advance and checked jumps
module stage_sequencer #(
  parameter int NUM_STAGES  = 5,
  parameter int NUM_SOURCES = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic              clk,
  input  logic              reset,
  stage_sequencer_if.slave  bus
);
  localparam int SEL_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  wrapped_q, wrapped_d;
  logic [CNT_WIDTH-1:0]  cycles_q, cycles_d, cycles_inc;
  logic                  err_q, err_d;
  logic                  sticky_q, sticky_d;
  logic [NUM_STAGES-1:0] jump_target;
  logic                  jump_hit;
  logic                  jump_ok;

  // State register: every output comes straight from a flop
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q   <= NUM_STAGES'(1);
      idx_q     <= '0;
      wrapped_q <= 1'b0;
      cycles_q  <= '0;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      idx_q     <= idx_d;
      wrapped_q <= wrapped_d;
      cycles_q  <= cycles_d;
      err_q     <= err_d;
      sticky_q  <= sticky_d;
    end
  end

  // Next state: stall beats jump beats advance beats hold; a bad jump holds and flags
  always_comb begin
    jump_target = '0;
    jump_hit    = 1'b0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (bus.jump_sel == SEL_W'(i)) begin
        jump_target = bus.jump_targets[i*NUM_STAGES +: NUM_STAGES];
        jump_hit    = 1'b1;
      end
    end
    jump_ok    = jump_hit && $onehot(jump_target);
    cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + CNT_WIDTH'(1);

    stage_d   = stage_q;
    cycles_d  = cycles_inc;
    wrapped_d = 1'b0;
    err_d     = 1'b0;
    sticky_d  = sticky_q;

    if (bus.stall) begin
      stage_d = stage_q;
    end else if (bus.jump_valid) begin
      if (jump_ok) begin
        stage_d  = jump_target;
        cycles_d = '0;
      end else begin
        err_d    = 1'b1;
        sticky_d = 1'b1;
      end
    end else if (bus.advance) begin
      stage_d   = {stage_q[NUM_STAGES-2:0], stage_q[NUM_STAGES-1]};
      cycles_d  = '0;
      wrapped_d = stage_q[NUM_STAGES-1];
    end

    idx_d = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stage_d[i]) idx_d = IDX_W'(i);
    end
  end

  // Outputs: drive the bundle from the registered state
  always_comb begin
    bus.stage           = stage_q;
    bus.stage_idx       = idx_q;
    bus.wrapped         = wrapped_q;
    bus.stage_cycles    = cycles_q;
    bus.jump_err        = err_q;
    bus.jump_err_sticky = sticky_q;
  end
endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - model-checked directed bench for stage_sequencer
module tb_stage_sequencer;
  localparam int NS   = 5;
  localparam int NSRC = 3;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stage_sequencer_if #(.NUM_STAGES(NS), .NUM_SOURCES(NSRC), .CNT_WIDTH(CW)) bus ();

  stage_sequencer #(.NUM_STAGES(NS), .NUM_SOURCES(NSRC), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int m_idx    = 0;
  int m_cyc    = 0;
  bit m_wr     = 1'b0;
  bit m_err    = 1'b0;
  bit m_sticky = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: track stage as an integer position and apply the priority rules
  always @(posedge clk) begin : model
    int t_sel;
    logic [NS-1:0] tgt;
    if (reset) begin
      m_idx = 0; m_cyc = 0; m_wr = 0; m_err = 0; m_sticky = 0;
    end else if (bus.stall) begin
      m_cyc = (m_cyc + 1 > CMAX) ? CMAX : m_cyc + 1;
      m_wr = 0; m_err = 0;
    end else if (bus.jump_valid) begin
      m_wr  = 0;
      t_sel = int'(bus.jump_sel);
      tgt   = '0;
      if (t_sel < NSRC) tgt = bus.jump_targets[t_sel*NS +: NS];
      if ($countones(tgt) == 1) begin
        for (int i = 0; i < NS; i++) if (tgt[i]) m_idx = i;
        m_cyc = 0; m_err = 0;
      end else begin
        m_cyc = (m_cyc + 1 > CMAX) ? CMAX : m_cyc + 1;
        m_err = 1; m_sticky = 1;
      end
    end else if (bus.advance) begin
      m_wr  = (m_idx == NS - 1);
      m_idx = (m_idx + 1) % NS;
      m_cyc = 0; m_err = 0;
    end else begin
      m_cyc = (m_cyc + 1 > CMAX) ? CMAX : m_cyc + 1;
      m_wr = 0; m_err = 0;
    end
  end

  // Compare every output against the model once per cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_stage",  32'(bus.stage),           32'(1 << m_idx));
      cmp("model_idx",    32'(bus.stage_idx),       32'(m_idx));
      cmp("model_cycles", 32'(bus.stage_cycles),    32'(m_cyc));
      cmp("model_wrap",   32'(bus.wrapped),         32'(m_wr));
      cmp("model_err",    32'(bus.jump_err),        32'(m_err));
      cmp("model_sticky", 32'(bus.jump_err_sticky), 32'(m_sticky));
    end
  end

  task automatic cyc(input logic r, input logic st, input logic adv, input logic jv, input logic [1:0] sel);
    reset          = r;
    bus.stall      = st;
    bus.advance    = adv;
    bus.jump_valid = jv;
    bus.jump_sel   = sel;
    @(negedge clk);
    #2;
  endtask

  int exp_stage [6] = '{2, 4, 8, 16, 1, 2};
  int exp_idx   [6] = '{1, 2, 3, 4, 0, 1};
  int exp_wrap  [6] = '{0, 0, 0, 0, 1, 0};

  initial begin
    reset            = 1'b1;
    bus.stall        = 1'b0;
    bus.advance      = 1'b0;
    bus.jump_valid   = 1'b0;
    bus.jump_sel     = 2'd0;
    bus.jump_targets = {5'b01000, 5'b00110, 5'b00010};
    #2;

    // 1: reset then rotate through all stages with one wrap
    cyc(1, 0, 0, 0, 0);
    chk_en = 1'b1;
    cyc(1, 0, 0, 0, 0);
    cmp("rst_stage",  32'(bus.stage),           32'h1);
    cmp("rst_idx",    32'(bus.stage_idx),       32'h0);
    cmp("rst_cycles", 32'(bus.stage_cycles),    32'h0);
    cmp("rst_wrap",   32'(bus.wrapped),         32'h0);
    cmp("rst_err",    32'(bus.jump_err),        32'h0);
    cmp("rst_sticky", 32'(bus.jump_err_sticky), 32'h0);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 1, 0, 0);
      cmp("adv_stage", 32'(bus.stage),     32'(exp_stage[k]));
      cmp("adv_idx",   32'(bus.stage_idx), 32'(exp_idx[k]));
      cmp("adv_wrap",  32'(bus.wrapped),   32'(exp_wrap[k]));
    end

    // 2: idle counts up and saturates at 7
    cyc(1, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      cyc(0, 0, 0, 0, 0);
      cmp("idle_cycles", 32'(bus.stage_cycles), 32'((k > 7) ? 7 : k));
      cmp("idle_stage",  32'(bus.stage),        32'h1);
    end

    // 3: valid jump wins over advance in the same cycle
    cyc(0, 0, 1, 1, 2'd2);
    cmp("jmp_stage",  32'(bus.stage),        32'h8);
    cmp("jmp_idx",    32'(bus.stage_idx),    32'd3);
    cmp("jmp_cycles", 32'(bus.stage_cycles), 32'd0);
    cmp("jmp_wrap",   32'(bus.wrapped),      32'd0);

    // 4: non-one-hot target and out-of-range source are both rejected
    cyc(0, 0, 0, 1, 2'd1);
    cmp("bad1_stage",  32'(bus.stage),           32'h8);
    cmp("bad1_err",    32'(bus.jump_err),        32'd1);
    cmp("bad1_sticky", 32'(bus.jump_err_sticky), 32'd1);
    cmp("bad1_cycles", 32'(bus.stage_cycles),    32'd1);
    cyc(0, 0, 0, 1, 2'd3);
    cmp("bad3_stage",  32'(bus.stage),           32'h8);
    cmp("bad3_err",    32'(bus.jump_err),        32'd1);
    cmp("bad3_cycles", 32'(bus.stage_cycles),    32'd2);
    cyc(0, 0, 0, 0, 0);
    cmp("post_err",    32'(bus.jump_err),        32'd0);
    cmp("post_sticky", 32'(bus.jump_err_sticky), 32'd1);

    // 5: stall masks a valid jump and an advance
    cyc(0, 1, 1, 1, 2'd0);
    cmp("stall_stage",  32'(bus.stage),        32'h8);
    cmp("stall_cycles", 32'(bus.stage_cycles), 32'd4);
    cmp("stall_err",    32'(bus.jump_err),     32'd0);

    // accepted jump to the current stage still clears the counter
    cyc(0, 0, 0, 1, 2'd2);
    cmp("same_stage",  32'(bus.stage),        32'h8);
    cmp("same_cycles", 32'(bus.stage_cycles), 32'd0);

    // 6: reset beats an advance out of the last stage
    cyc(0, 0, 1, 0, 0);
    cmp("last_stage", 32'(bus.stage), 32'h10);
    cyc(1, 0, 1, 0, 0);
    cmp("rstadv_stage",  32'(bus.stage),           32'h1);
    cmp("rstadv_wrap",   32'(bus.wrapped),         32'd0);
    cmp("rstadv_sticky", 32'(bus.jump_err_sticky), 32'd0);

    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
